sw_job_scheduler: RTL and testbench

//  Sequences SmithWaterman engine runs from a queue of host job descriptors.
//  Per job: drives scoring parameters, pulses start, tracks engine busy.

---
 rtl/sw_job_scheduler.sv | 274 +++++++++++++++++++++++++++
 tb/tb_sw_job_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_job_scheduler.sv
// sw_job_scheduler
// Takes job descriptors from the host and runs them one at a time on a
// Smith-Waterman engine. For each job it drives the scoring parameters,
// pulses start and follows the engine's busy flag. It stores one result per
// finished query in a result FIFO, then adds an end-of-job marker entry.

module sw_job_scheduler #(
    parameter int MATCH_BIT     = 4,
    parameter int CALC_BIT      = 16,
    parameter int MAX_T_NUM_BIT = 10,
    parameter int TAG_BIT       = 4,
    parameter int JOB_DEPTH     = 2,
    parameter int RES_DEPTH     = 8,
    parameter int BUSY_TIMEOUT  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     job_valid_i,
    output logic                     job_ready_o,
    input  logic [MATCH_BIT-1:0]     job_match_i,
    input  logic [MATCH_BIT-1:0]     job_mismatch_i,
    input  logic [MATCH_BIT-1:0]     job_alpha_i,
    input  logic [MATCH_BIT-1:0]     job_beta_i,
    input  logic [TAG_BIT-1:0]       job_tag_i,
    output logic                     sw_start_o,
    output logic [MATCH_BIT-1:0]     sw_match_o,
    output logic [MATCH_BIT-1:0]     sw_mismatch_o,
    output logic [MATCH_BIT-1:0]     sw_alpha_o,
    output logic [MATCH_BIT-1:0]     sw_beta_o,
    input  logic                     sw_busy_i,
    input  logic                     sw_change_q_i,
    input  logic [CALC_BIT-1:0]      sw_max_result_i,
    input  logic [MAX_T_NUM_BIT-1:0] sw_match_idx_i,
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    output logic [TAG_BIT-1:0]       res_tag_o,
    output logic [CALC_BIT-1:0]      res_score_o,
    output logic [MAX_T_NUM_BIT-1:0] res_idx_o,
    output logic                     res_last_o,
    output logic                     idle_o,
    output logic                     err_overflow_o,
    output logic                     err_timeout_o,
    input  logic                     err_clr_i
);

    // Both depths must be powers of two and at least 2, so a pointer wraps
    // correctly just by overflowing its natural width.
    localparam int JOB_AW = $clog2(JOB_DEPTH);
    localparam int JOB_CW = JOB_AW + 1;
    localparam int RES_AW = $clog2(RES_DEPTH);
    localparam int RES_CW = RES_AW + 1;
    localparam int TMR_W  = $clog2(BUSY_TIMEOUT + 1);

    typedef struct packed {
        logic [TAG_BIT-1:0]   tag;
        logic [MATCH_BIT-1:0] beta;
        logic [MATCH_BIT-1:0] alpha;
        logic [MATCH_BIT-1:0] mismatch;
        logic [MATCH_BIT-1:0] match;
    } job_t;

    typedef struct packed {
        logic [TAG_BIT-1:0]       tag;
        logic [CALC_BIT-1:0]      score;
        logic [MAX_T_NUM_BIT-1:0] idx;
        logic                     last;
    } res_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_BUSY,
        S_RUN,
        S_END
    } state_t;

    state_t state;

    job_t              job_mem [JOB_DEPTH];
    logic [JOB_AW-1:0] job_wr_ptr;
    logic [JOB_AW-1:0] job_rd_ptr;
    logic [JOB_CW-1:0] job_count;
    logic              job_full;
    logic              job_push;
    logic              job_pop;
    job_t              job_din;
    job_t              job_head;

    res_t              res_mem [RES_DEPTH];
    logic [RES_AW-1:0] res_wr_ptr;
    logic [RES_AW-1:0] res_rd_ptr;
    logic [RES_CW-1:0] res_count;
    logic              res_full;
    logic              res_push;
    logic              res_pop;
    logic              res_space;
    res_t              res_din;
    res_t              res_head;

    logic              capture_req;
    logic              marker_req;
    logic              overflow_set;
    logic [TAG_BIT-1:0] cur_tag;
    logic [TMR_W-1:0]  busy_timer;

    // The job FIFO pops only in LOAD, and the FSM only enters LOAD when the
    // FIFO holds a job. A push is also accepted when the FIFO is full if a
    // pop happens in the same cycle.
    assign job_full    = (job_count == JOB_CW'(JOB_DEPTH));
    assign job_pop     = (state == S_LOAD);
    assign job_ready_o = !job_full || job_pop;
    assign job_push    = job_valid_i && job_ready_o;
    assign job_din     = '{tag: job_tag_i, beta: job_beta_i, alpha: job_alpha_i,
                           mismatch: job_mismatch_i, match: job_match_i};
    assign job_head    = job_mem[job_rd_ptr];

    // The result FIFO has room if it is not full, or if the consumer pops in
    // this same cycle. The engine is never stalled: a query result that
    // arrives with no room is dropped.
    assign res_full     = (res_count == RES_CW'(RES_DEPTH));
    assign res_valid_o  = (res_count != '0);
    assign res_pop      = res_valid_o && res_ready_i;
    assign res_space    = !res_full || res_pop;
    assign capture_req  = sw_change_q_i && ((state == S_WAIT_BUSY) || (state == S_RUN));
    assign marker_req   = (state == S_END) && res_space;
    assign overflow_set = capture_req && !res_space;
    assign res_push     = (capture_req && res_space) || marker_req;
    assign res_din      = marker_req ? '{tag: cur_tag, score: '0, idx: '0, last: 1'b1}
                                     : '{tag: cur_tag, score: sw_max_result_i,
                                         idx: sw_match_idx_i, last: 1'b0};
    assign res_head     = res_mem[res_rd_ptr];

    // The result outputs show the head entry. They read as zero while the
    // FIFO is empty, so reset and stale memory contents never reach them.
    assign res_tag_o   = res_valid_o ? res_head.tag   : '0;
    assign res_score_o = res_valid_o ? res_head.score : '0;
    assign res_idx_o   = res_valid_o ? res_head.idx   : '0;
    assign res_last_o  = res_valid_o ? res_head.last  : 1'b0;

    assign idle_o = (state == S_IDLE) && (job_count == '0);

    // Job descriptor storage (data path only, no reset needed)
    always_ff @(posedge clk) begin
        if (job_push) begin
            job_mem[job_wr_ptr] <= job_din;
        end
    end

    // Job FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            job_wr_ptr <= '0;
            job_rd_ptr <= '0;
            job_count  <= '0;
        end else begin
            if (job_push) begin
                job_wr_ptr <= job_wr_ptr + 1'b1;
            end
            if (job_pop) begin
                job_rd_ptr <= job_rd_ptr + 1'b1;
            end
            if (job_push && !job_pop) begin
                job_count <= job_count + 1'b1;
            end else if (!job_push && job_pop) begin
                job_count <= job_count - 1'b1;
            end
        end
    end

    // Result entry storage (data path only, no reset needed)
    always_ff @(posedge clk) begin
        if (res_push) begin
            res_mem[res_wr_ptr] <= res_din;
        end
    end

    // Result FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_wr_ptr <= '0;
            res_rd_ptr <= '0;
            res_count  <= '0;
        end else begin
            if (res_push) begin
                res_wr_ptr <= res_wr_ptr + 1'b1;
            end
            if (res_pop) begin
                res_rd_ptr <= res_rd_ptr + 1'b1;
            end
            if (res_push && !res_pop) begin
                res_count <= res_count + 1'b1;
            end else if (!res_push && res_pop) begin
                res_count <= res_count - 1'b1;
            end
        end
    end

    // Sticky overflow flag. A new drop wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_overflow_o <= 1'b0;
        end else if (overflow_set) begin
            err_overflow_o <= 1'b1;
        end else if (err_clr_i) begin
            err_overflow_o <= 1'b0;
        end
    end

    // Job sequencing FSM. It also registers the engine parameters, the start
    // pulse and the busy-timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            sw_start_o    <= 1'b0;
            sw_match_o    <= '0;
            sw_mismatch_o <= '0;
            sw_alpha_o    <= '0;
            sw_beta_o     <= '0;
            cur_tag       <= '0;
            busy_timer    <= '0;
            err_timeout_o <= 1'b0;
        end else begin
            if (err_clr_i) begin
                err_timeout_o <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (job_count != '0) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    sw_match_o    <= job_head.match;
                    sw_mismatch_o <= job_head.mismatch;
                    sw_alpha_o    <= job_head.alpha;
                    sw_beta_o     <= job_head.beta;
                    cur_tag       <= job_head.tag;
                    sw_start_o    <= 1'b1;
                    state         <= S_START;
                end
                S_START: begin
                    sw_start_o <= 1'b0;
                    busy_timer <= TMR_W'(BUSY_TIMEOUT);
                    state      <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (sw_busy_i) begin
                        state <= S_RUN;
                    end else if (busy_timer == TMR_W'(1)) begin
                        err_timeout_o <= 1'b1;
                        state         <= S_END;
                    end else begin
                        busy_timer <= busy_timer - 1'b1;
                    end
                end
                S_RUN: begin
                    if (!sw_busy_i) begin
                        state <= S_END;
                    end
                end
                S_END: begin
                    if (marker_req) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sw_job_scheduler.sv
// tb_sw_job_scheduler
// Directed bench for sw_job_scheduler. The engine is modelled inline by
// driving busy, change_q and the result pins from the stimulus sequence.

module tb_sw_job_scheduler;

    logic        clk;
    logic        rst_n;
    logic        job_valid_i;
    logic        job_ready_o;
    logic [3:0]  job_match_i;
    logic [3:0]  job_mismatch_i;
    logic [3:0]  job_alpha_i;
    logic [3:0]  job_beta_i;
    logic [3:0]  job_tag_i;
    logic        sw_start_o;
    logic [3:0]  sw_match_o;
    logic [3:0]  sw_mismatch_o;
    logic [3:0]  sw_alpha_o;
    logic [3:0]  sw_beta_o;
    logic        sw_busy_i;
    logic        sw_change_q_i;
    logic [15:0] sw_max_result_i;
    logic [9:0]  sw_match_idx_i;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [3:0]  res_tag_o;
    logic [15:0] res_score_o;
    logic [9:0]  res_idx_o;
    logic        res_last_o;
    logic        idle_o;
    logic        err_overflow_o;
    logic        err_timeout_o;
    logic        err_clr_i;

    int testCount = 0;
    int failCount = 0;

    sw_job_scheduler dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .job_valid_i     (job_valid_i),
        .job_ready_o     (job_ready_o),
        .job_match_i     (job_match_i),
        .job_mismatch_i  (job_mismatch_i),
        .job_alpha_i     (job_alpha_i),
        .job_beta_i      (job_beta_i),
        .job_tag_i       (job_tag_i),
        .sw_start_o      (sw_start_o),
        .sw_match_o      (sw_match_o),
        .sw_mismatch_o   (sw_mismatch_o),
        .sw_alpha_o      (sw_alpha_o),
        .sw_beta_o       (sw_beta_o),
        .sw_busy_i       (sw_busy_i),
        .sw_change_q_i   (sw_change_q_i),
        .sw_max_result_i (sw_max_result_i),
        .sw_match_idx_i  (sw_match_idx_i),
        .res_valid_o     (res_valid_o),
        .res_ready_i     (res_ready_i),
        .res_tag_o       (res_tag_o),
        .res_score_o     (res_score_o),
        .res_idx_o       (res_idx_o),
        .res_last_o      (res_last_o),
        .idle_o          (idle_o),
        .err_overflow_o  (err_overflow_o),
        .err_timeout_o   (err_timeout_o),
        .err_clr_i       (err_clr_i)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and settle just after the rising edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] observed,
                               input logic [63:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    // Offer one job descriptor for a single cycle
    task automatic applyStimulus(input logic [3:0] m, input logic [3:0] mm,
                                 input logic [3:0] a, input logic [3:0] b,
                                 input logic [3:0] tag);
        job_valid_i    = 1'b1;
        job_match_i    = m;
        job_mismatch_i = mm;
        job_alpha_i    = a;
        job_beta_i     = b;
        job_tag_i      = tag;
        tick();
        job_valid_i = 1'b0;
    endtask

    // Wait (bounded) for the start pulse
    task automatic waitStart;
        for (int i = 0; i < 20; i++) begin
            if (sw_start_o) break;
            tick();
        end
        checkOutput("start_seen", sw_start_o, 1);
    endtask

    // Wait (bounded) for the scheduler to become idle
    task automatic waitIdle;
        for (int i = 0; i < 50; i++) begin
            if (idle_o) break;
            tick();
        end
        checkOutput("idle_reached", idle_o, 1);
    endtask

    // Check the head of the result FIFO, then pop it
    task automatic popCheck(input logic [3:0] tag, input logic [15:0] score,
                            input logic [9:0] idx, input logic last);
        checkOutput("res_valid", res_valid_o, 1);
        checkOutput("res_tag", res_tag_o, tag);
        checkOutput("res_score", res_score_o, score);
        checkOutput("res_idx", res_idx_o, idx);
        checkOutput("res_last", res_last_o, last);
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
    endtask

    // Engine model for one job. Pulse k reports score scoreBase-2k and index
    // 100+k on odd busy cycles. popLast pops the consumer side in the same
    // cycle as the last pulse.
    task automatic runJob(input logic [3:0] m, input logic [3:0] mm,
                          input logic [3:0] a, input logic [3:0] b,
                          input int busyCycles, input int nPulses,
                          input logic [15:0] scoreBase, input logic popLast);
        int k;
        waitStart();
        checkOutput("start_params", {sw_match_o, sw_mismatch_o, sw_alpha_o, sw_beta_o},
                    {m, mm, a, b});
        tick();
        job_valid_i = 1'b0;
        checkOutput("start_one_cycle", sw_start_o, 0);
        sw_busy_i = 1'b1;
        k = 0;
        for (int c = 0; c < busyCycles; c++) begin
            if ((c % 2 == 1) && (k < nPulses)) begin
                sw_change_q_i   = 1'b1;
                sw_max_result_i = scoreBase - 16'(2 * k);
                sw_match_idx_i  = 10'(100 + k);
                if (popLast && (k == nPulses - 1)) res_ready_i = 1'b1;
                k++;
            end
            tick();
            sw_change_q_i = 1'b0;
            res_ready_i   = 1'b0;
            checkOutput("param_hold", {sw_match_o, sw_mismatch_o, sw_alpha_o, sw_beta_o},
                        {m, mm, a, b});
            checkOutput("no_restart", sw_start_o, 0);
        end
        sw_busy_i = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        job_valid_i     = 1'b0;
        job_match_i     = '0;
        job_mismatch_i  = '0;
        job_alpha_i     = '0;
        job_beta_i      = '0;
        job_tag_i       = '0;
        sw_busy_i       = 1'b0;
        sw_change_q_i   = 1'b0;
        sw_max_result_i = '0;
        sw_match_idx_i  = '0;
        res_ready_i     = 1'b0;
        err_clr_i       = 1'b0;

        // Reset values
        repeat (3) tick();
        checkOutput("rst_job_ready", job_ready_o, 1);
        checkOutput("rst_idle", idle_o, 1);
        checkOutput("rst_res_valid", res_valid_o, 0);
        checkOutput("rst_start", sw_start_o, 0);
        checkOutput("rst_params", {sw_match_o, sw_mismatch_o, sw_alpha_o, sw_beta_o}, 0);
        checkOutput("rst_errs", {err_overflow_o, err_timeout_o}, 0);
        checkOutput("rst_res_out", {res_tag_o, res_score_o, res_idx_o, res_last_o}, 0);
        rst_n = 1'b1;
        tick();

        // Single job, two query results, then the end marker
        applyStimulus(4'd2, 4'd1, 4'd2, 4'd1, 4'd3);
        checkOutput("t1_not_idle", idle_o, 0);
        tick();
        checkOutput("t1_no_start_in_load", sw_start_o, 0);
        tick();
        checkOutput("t1_start_latency", sw_start_o, 1);
        runJob(4'd2, 4'd1, 4'd2, 4'd1, 20, 2, 16'd7, 1'b0);
        waitIdle();
        popCheck(4'd3, 16'd7, 10'd100, 1'b0);
        popCheck(4'd3, 16'd5, 10'd101, 1'b0);
        popCheck(4'd3, 16'd0, 10'd0, 1'b1);
        checkOutput("t1_res_empty", res_valid_o, 0);

        // Three jobs back-to-back, the job FIFO fills, and an extra offer is ignored
        applyStimulus(4'd1, 4'd2, 4'd3, 4'd4, 4'd1);
        applyStimulus(4'd5, 4'd6, 4'd7, 4'd8, 4'd2);
        applyStimulus(4'd9, 4'd10, 4'd11, 4'd12, 4'd3);
        checkOutput("t2_job_full", job_ready_o, 0);
        job_valid_i    = 1'b1;
        job_match_i    = 4'd15;
        job_mismatch_i = 4'd15;
        job_alpha_i    = 4'd15;
        job_beta_i     = 4'd15;
        job_tag_i      = 4'd9;
        runJob(4'd1, 4'd2, 4'd3, 4'd4, 4, 1, 16'd10, 1'b0);
        runJob(4'd5, 4'd6, 4'd7, 4'd8, 4, 1, 16'd20, 1'b0);
        runJob(4'd9, 4'd10, 4'd11, 4'd12, 4, 1, 16'd30, 1'b0);
        waitIdle();
        popCheck(4'd1, 16'd10, 10'd100, 1'b0);
        popCheck(4'd1, 16'd0, 10'd0, 1'b1);
        popCheck(4'd2, 16'd20, 10'd100, 1'b0);
        popCheck(4'd2, 16'd0, 10'd0, 1'b1);
        popCheck(4'd3, 16'd30, 10'd100, 1'b0);
        popCheck(4'd3, 16'd0, 10'd0, 1'b1);
        checkOutput("t2_no_extra_job", res_valid_o, 0);

        // Overflow: nine results with no consumer; the marker waits for space
        applyStimulus(4'd4, 4'd4, 4'd4, 4'd4, 4'd5);
        runJob(4'd4, 4'd4, 4'd4, 4'd4, 20, 9, 16'd100, 1'b0);
        checkOutput("t3_overflow", err_overflow_o, 1);
        repeat (3) tick();
        checkOutput("t3_end_stalled", idle_o, 0);
        popCheck(4'd5, 16'd100, 10'd100, 1'b0);
        checkOutput("t3_marker_pushed", idle_o, 1);
        for (int k = 1; k < 8; k++) begin
            popCheck(4'd5, 16'(100 - 2 * k), 10'(100 + k), 1'b0);
        end
        popCheck(4'd5, 16'd0, 10'd0, 1'b1);
        checkOutput("t3_res_empty", res_valid_o, 0);
        checkOutput("t3_overflow_sticky", err_overflow_o, 1);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        checkOutput("t3_overflow_cleared", err_overflow_o, 0);

        // Push and pop on a full result FIFO in the same cycle
        applyStimulus(4'd1, 4'd1, 4'd1, 4'd1, 4'd6);
        runJob(4'd1, 4'd1, 4'd1, 4'd1, 20, 9, 16'd200, 1'b1);
        checkOutput("t6_no_overflow", err_overflow_o, 0);
        repeat (2) tick();
        checkOutput("t6_end_stalled", idle_o, 0);
        for (int k = 1; k < 9; k++) begin
            popCheck(4'd6, 16'(200 - 2 * k), 10'(100 + k), 1'b0);
        end
        popCheck(4'd6, 16'd0, 10'd0, 1'b1);
        checkOutput("t6_res_empty", res_valid_o, 0);

        // Busy timeout
        applyStimulus(4'd8, 4'd7, 4'd6, 4'd5, 4'd7);
        waitStart();
        repeat (4) tick();
        checkOutput("t4_no_timeout_yet", err_timeout_o, 0);
        tick();
        checkOutput("t4_timeout", err_timeout_o, 1);
        tick();
        checkOutput("t4_idle_after", idle_o, 1);
        popCheck(4'd7, 16'd0, 10'd0, 1'b1);
        checkOutput("t4_timeout_sticky", err_timeout_o, 1);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        checkOutput("t4_timeout_cleared", err_timeout_o, 0);

        // Reset asserted during RUN, then a normal job
        applyStimulus(4'd3, 4'd3, 4'd3, 4'd3, 4'd2);
        waitStart();
        tick();
        sw_busy_i = 1'b1;
        tick();
        sw_change_q_i   = 1'b1;
        sw_max_result_i = 16'd55;
        sw_match_idx_i  = 10'd5;
        tick();
        sw_change_q_i = 1'b0;
        checkOutput("t5_captured", res_valid_o, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_idle", idle_o, 1);
        checkOutput("t5_rst_res_valid", res_valid_o, 0);
        checkOutput("t5_rst_params", {sw_match_o, sw_mismatch_o, sw_alpha_o, sw_beta_o}, 0);
        checkOutput("t5_rst_job_ready", job_ready_o, 1);
        checkOutput("t5_rst_start", sw_start_o, 0);
        sw_busy_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        applyStimulus(4'd4, 4'd3, 4'd2, 4'd1, 4'd4);
        runJob(4'd4, 4'd3, 4'd2, 4'd1, 4, 1, 16'd44, 1'b0);
        waitIdle();
        popCheck(4'd4, 16'd44, 10'd100, 1'b0);
        popCheck(4'd4, 16'd0, 10'd0, 1'b1);
        checkOutput("t5_res_empty", res_valid_o, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
